// File: rtl/vga_pkg.sv
// Shared 1024x768@60 Hz raster constants for the timing generator, draw_background
// and the game logic.
package vga_pkg;

  // Horizontal timing in pixels.
  localparam int H_VIS   = 1024;
  localparam int H_FP    = 24;
  localparam int H_SYNC  = 136;
  localparam int H_BP    = 160;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines.
  localparam int V_VIS   = 768;
  localparam int V_FP    = 3;
  localparam int V_SYNC  = 6;
  localparam int V_BP    = 29;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Sync windows, inclusive on both ends.
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Grid cell edge in pixels; must be a power of two.
  localparam int GRID_SIZE = 16;

  // Port widths of the timing bus and the grid coordinates.
  localparam int CNT_W  = 11;
  localparam int GRID_W = 7;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with enable and wrap, registered blank/sync
// decode, and a grid-cell coordinate kept incrementally alongside the counter.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VIS        = H_VIS,
  parameter int TOTAL      = H_TOTAL,
  parameter int SYNC_START = H_SYNC_START,
  parameter int SYNC_END   = H_SYNC_END,
  parameter int GRID_SIZE  = vga_pkg::GRID_SIZE
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              en,
  output logic [CNT_W-1:0]  cnt,
  output logic              blnk,
  output logic              sync,
  output logic [GRID_W-1:0] grid,
  output logic              wrap
);

  localparam int SUB_W = $clog2(GRID_SIZE);

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_C  = CNT_W'(VIS);
  localparam logic [CNT_W-1:0] SS_C   = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SE_C   = CNT_W'(SYNC_END);

  logic [CNT_W-1:0]  cnt_nxt;
  logic [SUB_W-1:0]  sub, sub_nxt;
  logic [GRID_W-1:0] grid_nxt;

  // Wrap is seen by the next axis as its enable in the same cycle.
  assign wrap = en && (cnt == LAST_C);

  // Next position: step when enabled, clear everything on wrap, bump the grid
  // coordinate whenever the sub-counter rolls over.
  always_comb begin
    cnt_nxt  = cnt;
    sub_nxt  = sub;
    grid_nxt = grid;
    if (en) begin
      if (cnt == LAST_C) begin
        cnt_nxt  = '0;
        sub_nxt  = '0;
        grid_nxt = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
        sub_nxt = sub + SUB_W'(1);
        if (&sub) begin
          grid_nxt = grid + GRID_W'(1);
        end
      end
    end
  end

  // Register position and decode flags from the next value so flags line up
  // with the position they describe.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sub  <= '0;
      grid <= '0;
      blnk <= 1'b0;
      sync <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      sub  <= sub_nxt;
      grid <= grid_nxt;
      blnk <= (cnt_nxt >= VIS_C);
      sync <= (cnt_nxt >= SS_C) && (cnt_nxt <= SE_C);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: horizontal and vertical axis counters plus a
// start-of-frame pulse and a completed-frame counter for the game logic.
module vga_timing_gen #(
  parameter int H_VIS     = vga_pkg::H_VIS,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VIS     = vga_pkg::V_VIS,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP,
  parameter int GRID_SIZE = vga_pkg::GRID_SIZE
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [6:0]  grid_x,
  output logic [6:0]  grid_y,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SS    = H_VIS + H_FP;
  localparam int H_SE    = H_SS + H_SYNC - 1;
  localparam int V_SS    = V_VIS + V_FP;
  localparam int V_SE    = V_SS + V_SYNC - 1;

  logic        h_wrap;
  logic        v_wrap;
  logic [15:0] frame_count_q;

  vga_axis_counter #(
    .VIS        (H_VIS),
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_SS),
    .SYNC_END   (H_SE),
    .GRID_SIZE  (GRID_SIZE)
  ) u_h_axis (
    .pclk (pclk),
    .rst  (rst),
    .en   (1'b1),
    .cnt  (hcount_out),
    .blnk (hblnk_out),
    .sync (hsync_out),
    .grid (grid_x),
    .wrap (h_wrap)
  );

  vga_axis_counter #(
    .VIS        (V_VIS),
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_SS),
    .SYNC_END   (V_SE),
    .GRID_SIZE  (GRID_SIZE)
  ) u_v_axis (
    .pclk (pclk),
    .rst  (rst),
    .en   (h_wrap),
    .cnt  (vcount_out),
    .blnk (vblnk_out),
    .sync (vsync_out),
    .grid (grid_y),
    .wrap (v_wrap)
  );

  // Vertical wrap is the last pixel of the frame, so the tick and count update
  // land in the same cycle the counters show (0,0); reset itself never ticks.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      frame_tick    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_tick <= v_wrap;
      if (v_wrap) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a scaled-down raster instance covering whole frames,
// frame-count rollover and mid-frame resets, plus a default-parameter instance
// covering the first lines of the real 1024x768 raster.
module tb_vga_timing_gen;

  // Scaled raster: 64 x 30 with 4-pixel cells, 1920 cycles per frame.
  localparam int S_HVIS = 40, S_HFP = 4, S_HSYNC = 8, S_HBP = 12;
  localparam int S_VVIS = 20, S_VFP = 2, S_VSYNC = 3, S_VBP = 5;
  localparam int S_GS   = 4;
  localparam int S_HT   = S_HVIS + S_HFP + S_HSYNC + S_HBP;
  localparam int S_VT   = S_VVIS + S_VFP + S_VSYNC + S_VBP;
  localparam int S_F    = S_HT * S_VT;

  // Real raster constants written out independently of the package.
  localparam int D_HT = 1344, D_HVIS = 1024, D_HSS = 1048, D_HSE = 1183;
  localparam int D_VT = 806,  D_VVIS = 768,  D_VSS = 771,  D_VSE = 776;
  localparam int D_GS = 16;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  // ---------------- DUTs ----------------
  logic [10:0] hc_s, vc_s, hc_d, vc_d;
  logic        hs_s, hb_s, vs_s, vb_s, ft_s;
  logic        hs_d, hb_d, vs_d, vb_d, ft_d;
  logic [6:0]  gx_s, gy_s, gx_d, gy_d;
  logic [15:0] fc_s, fc_d;

  vga_timing_gen #(
    .H_VIS (S_HVIS), .H_FP (S_HFP), .H_SYNC (S_HSYNC), .H_BP (S_HBP),
    .V_VIS (S_VVIS), .V_FP (S_VFP), .V_SYNC (S_VSYNC), .V_BP (S_VBP),
    .GRID_SIZE (S_GS)
  ) dut_s (
    .pclk (pclk), .rst (rst),
    .hcount_out (hc_s), .hsync_out (hs_s), .hblnk_out (hb_s),
    .vcount_out (vc_s), .vsync_out (vs_s), .vblnk_out (vb_s),
    .grid_x (gx_s), .grid_y (gy_s),
    .frame_tick (ft_s), .frame_count (fc_s)
  );

  vga_timing_gen dut_d (
    .pclk (pclk), .rst (rst),
    .hcount_out (hc_d), .hsync_out (hs_d), .hblnk_out (hb_d),
    .vcount_out (vc_d), .vsync_out (vs_d), .vblnk_out (vb_d),
    .grid_x (gx_d), .grid_y (gy_d),
    .frame_tick (ft_d), .frame_count (fc_d)
  );

  // Packed view: {hcount, vcount, hsync, hblnk, vsync, vblnk, grid_x, grid_y, tick, count}
  logic [56:0] act_s, act_d;
  assign act_s = {hc_s, vc_s, hs_s, hb_s, vs_s, vb_s, gx_s, gy_s, ft_s, fc_s};
  assign act_d = {hc_d, vc_d, hs_d, hb_d, vs_d, vb_d, gx_d, gy_d, ft_d, fc_d};

  // ---------------- reference model ----------------
  // n = pixel clocks since the raster left reset; everything follows by arithmetic.
  function automatic logic [56:0] model(input int n, input int ht, input int hvis,
                                        input int hss, input int hse, input int vt,
                                        input int vvis, input int vss, input int vse,
                                        input int gs, input logic [15:0] fcb);
    int h, v, fr;
    logic tick;
    logic [15:0] fc;
    h    = n % ht;
    v    = (n / ht) % vt;
    fr   = n / (ht * vt);
    tick = (n > 0) && (h == 0) && (v == 0);
    fc   = fcb + 16'(fr);
    return {11'(h), 11'(v), (h >= hss && h <= hse), (h >= hvis),
            (v >= vss && v <= vse), (v >= vvis), 7'(h / gs), 7'(v / gs), tick, fc};
  endfunction

  // ---------------- scoreboard ----------------
  logic [56:0] exp_s_q[$];
  logic [56:0] exp_d_q[$];
  int n_cyc = 0;
  logic [15:0] fc_base = '0;
  int tests = 0;
  int fails = 0;

  task automatic push_expected();
    exp_s_q.push_back(model(n_cyc, S_HT, S_HVIS, S_HVIS + S_HFP, S_HVIS + S_HFP + S_HSYNC - 1,
                            S_VT, S_VVIS, S_VVIS + S_VFP, S_VVIS + S_VFP + S_VSYNC - 1,
                            S_GS, fc_base));
    exp_d_q.push_back(model(n_cyc, D_HT, D_HVIS, D_HSS, D_HSE, D_VT, D_VVIS, D_VSS, D_VSE,
                            D_GS, 16'd0));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: advance the model across the edge, then apply the new reset level.
  task automatic step(input logic r);
    logic rst_at_edge;
    @(posedge pclk);
    rst_at_edge = rst;
    #2;
    if (rst_at_edge) n_cyc = 0;
    else n_cyc++;
    rst = r;
    if (r) begin
      n_cyc   = 0;
      fc_base = '0;
    end
    push_expected();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step(1'b0);
  endtask

  // Preload the scaled instance's frame counter to 0xFFFF mid-run.
  task automatic preload_ffff();
    @(posedge pclk);
    #2;
    n_cyc++;
    force dut_s.frame_count_q = 16'hFFFF;
    fc_base = 16'hFFFF - 16'(n_cyc / S_F);
    push_expected();
    #1;
    release dut_s.frame_count_q;
  endtask

  // ---------------- monitor ----------------
  // Compare mid-cycle, away from the active edge.
  always @(negedge pclk) begin
    logic [56:0] e;
    if (exp_s_q.size() > 0) begin
      e = exp_s_q.pop_front();
      tests++;
      if (act_s !== e) begin
        fails++;
        $display("FAIL scaled_raster n=%0d: got h=%0d v=%0d hs%b hb%b vs%b vb%b gx=%0d gy=%0d tick%b fc=%h, expected %h (got %h)",
                 n_cyc, hc_s, vc_s, hs_s, hb_s, vs_s, vb_s, gx_s, gy_s, ft_s, fc_s, e, act_s);
      end
    end
    if (exp_d_q.size() > 0) begin
      e = exp_d_q.pop_front();
      tests++;
      if (act_d !== e) begin
        fails++;
        $display("FAIL default_raster n=%0d: got h=%0d v=%0d hs%b hb%b vs%b vb%b gx=%0d gy=%0d tick%b fc=%h, expected %h (got %h)",
                 n_cyc, hc_d, vc_d, hs_d, hb_d, vs_d, vb_d, gx_d, gy_d, ft_d, fc_d, e, act_d);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b1);
    // Two full scaled frames plus the first lines of the real raster.
    run(2 * S_F + 100);
    // Random mid-frame resets, each followed by more than a full frame.
    for (int k = 0; k < 2; k++) begin
      run($urandom_range(200, 1500));
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) step(1'b1);
      run(S_F + 50);
    end
    // Frame-count rollover across a frame boundary.
    run($urandom_range(100, S_F - 200));
    preload_ffff();
    run(S_F + 20);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && (exp_s_q.size() > 0 || exp_d_q.size() > 0); i++) @(negedge pclk);
    @(negedge pclk);
    tests++;
    if (exp_s_q.size() != 0 || exp_d_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0",
               exp_s_q.size(), exp_d_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
